led_matrix_scanner: RTL

Parametrised row-multiplexed LED matrix driver, the successor to the fixed 8x8 scan logic.
- Accepts whole frames over a valid/ready handshake into a shadow buffer.
- Swaps the shadow buffer into the display buffer only at frame boundaries, so there is no tearing.
- Scans rows one-hot, with a programmable blanking gap before each row to suppress ghosting.
- Sits between the cell-matrix generator and the board pins.

---
 rtl/led_scan_pkg.sv | 19 +
 rtl/led_frame_dbuf.sv | 66 ++++++
 rtl/led_matrix_scanner.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and constants for the row-multiplexed LED matrix scanner.
package led_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

  // Single-bit off levels; replicated to the row/column width at use.
  localparam logic ROW_OFF  = 1'b0;
  localparam logic DATA_OFF = 1'b1;

  // Counter width for a count of 0..bound-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/led_frame_dbuf.sv
// Shadow/display frame buffers with a one-deep pending flag; swaps on the frame wrap.
module led_frame_dbuf
  import led_scan_pkg::*;
#(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) (
  input  logic                 clk_2,
  input  logic                 _rst,
  input  logic                 frame_valid,
  input  logic [ROWS*COLS-1:0] frame_data,
  input  logic                 idle,
  input  logic                 wrap,
  output logic                 frame_ready,
  output logic                 accept,
  output logic [ROWS*COLS-1:0] display
);

  logic [ROWS*COLS-1:0] display_q, display_d;
  logic [ROWS*COLS-1:0] shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic                 ready_q, ready_d;
  logic                 swap;

  // ready_q is only high while nothing is pending, so data is never sampled then.
  assign accept = frame_valid && ready_q;
  assign swap   = wrap && pending_q;

  always_comb begin
    display_d = display_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (swap) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      if (idle) begin
        display_d = frame_data;
      end else begin
        shadow_d  = frame_data;
        pending_d = 1'b1;
      end
    end
    // Ready comes back one edge after the swap, not on the swap edge itself.
    ready_d = ~pending_d & ~swap;
  end

  always_ff @(posedge clk_2 or negedge _rst) begin
    if (!_rst) begin
      display_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      display_q <= display_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
    end
  end

  assign frame_ready = ready_q;
  assign display     = display_q;

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver: blank/drive scan FSM with tear-free frame swap.
// Optional LED_SCAN_BRIGHTNESS_EN adds a per-row brightness (dwell duty) input.
module led_matrix_scanner
  import led_scan_pkg::*;
#(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned BLANK_CYCLES = 1,
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic                 clk_2,
  input  logic                 _rst,
  input  logic                 frame_valid,
  input  logic [ROWS*COLS-1:0] frame_data,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [$clog2(DWELL_CYCLES+1)-1:0] brightness,
`endif
  output logic                 frame_ready,
  output logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      data_n,
  output logic                 frame_done
);

  localparam int unsigned RowW   = cnt_width(ROWS);
  localparam int unsigned BlankW = cnt_width(BLANK_CYCLES);
  localparam int unsigned DwellW = cnt_width(DWELL_CYCLES);

  localparam logic [RowW-1:0]   RowLast   = RowW'(ROWS - 1);
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);

  scan_state_t          state_q, state_d;
  logic [RowW-1:0]      row_idx_q, row_idx_d;
  logic [BlankW-1:0]    blank_cnt_q, blank_cnt_d;
  logic [DwellW-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [ROWS-1:0]      row_q, row_d;
  logic [COLS-1:0]      data_n_q, data_n_d;
  logic                 frame_done_q, frame_done_d;
  logic                 accept, wrap, drive_on;
  logic [ROWS*COLS-1:0] display;

  led_frame_dbuf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_dbuf (
    .clk_2       (clk_2),
    ._rst        (_rst),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .idle        (state_q == S_IDLE),
    .wrap        (wrap),
    .frame_ready (frame_ready),
    .accept      (accept),
    .display     (display)
  );

  assign wrap = (state_q == S_DRIVE) && (dwell_cnt_q == DwellLast) && (row_idx_q == RowLast);

  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    blank_cnt_d = blank_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_BLANK;
          row_idx_d   = '0;
          blank_cnt_d = '0;
        end
      end
      S_BLANK: begin
        if (blank_cnt_q == BlankLast) begin
          state_d     = S_DRIVE;
          dwell_cnt_d = '0;
        end else begin
          blank_cnt_d = blank_cnt_q + BlankW'(1);
        end
      end
      S_DRIVE: begin
        if (dwell_cnt_q == DwellLast) begin
          state_d     = S_BLANK;
          blank_cnt_d = '0;
          row_idx_d   = (row_idx_q == RowLast) ? '0 : row_idx_q + RowW'(1);
        end else begin
          dwell_cnt_d = dwell_cnt_q + DwellW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LED_SCAN_BRIGHTNESS_EN
  localparam int unsigned BrW = $clog2(DWELL_CYCLES + 1);
  logic [BrW-1:0] bright_q, bright_d, bright_eff;

  // Brightness is taken live on the first dwell cycle and held for the rest of the row.
  assign bright_eff = (dwell_cnt_q == '0) ? brightness : bright_q;
  assign bright_d   = (state_q == S_DRIVE && dwell_cnt_q == '0) ? brightness : bright_q;
  assign drive_on   = (state_q == S_DRIVE) && (BrW'(dwell_cnt_q) < bright_eff);

  always_ff @(posedge clk_2 or negedge _rst) begin
    if (!_rst) bright_q <= '0;
    else       bright_q <= bright_d;
  end
`else
  assign drive_on = (state_q == S_DRIVE);
`endif

  // Outputs register the current state, so they trail the FSM by one edge.
  always_comb begin
    row_d        = {ROWS{ROW_OFF}};
    data_n_d     = {COLS{DATA_OFF}};
    frame_done_d = wrap;
    if (drive_on) begin
      row_d    = ROWS'(1) << row_idx_q;
      data_n_d = ~display[row_idx_q*COLS +: COLS];
    end
  end

  always_ff @(posedge clk_2 or negedge _rst) begin
    if (!_rst) begin
      state_q      <= S_IDLE;
      row_idx_q    <= '0;
      blank_cnt_q  <= '0;
      dwell_cnt_q  <= '0;
      row_q        <= {ROWS{ROW_OFF}};
      data_n_q     <= {COLS{DATA_OFF}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      blank_cnt_q  <= blank_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      row_q        <= row_d;
      data_n_q     <= data_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row        = row_q;
  assign data_n     = data_n_q;
  assign frame_done = frame_done_q;

endmodule
